// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb
//   Single-port memory arbiter/sequencer shared by instruction fetch (IF) and
//   the load/store unit (LS). Accepts one request at a time with round-robin
//   arbitration, runs the memory request/grant handshake, waits for the
//   response (bounded by a watchdog) and returns it to the owning requester.
//
// Parameters
//   TIMEOUT      : WAIT cycles before an access is aborted with err (1..255)
//
// Ports
//   clk_i, rst_i               : clock, synchronous active-high reset
//   if_req_i, if_addr_i        : IF read request and word address
//   if_gnt_o, if_rvalid_o      : IF accepted this cycle / IF response pulse
//   ls_req_i, ls_we_i,
//   ls_addr_i, ls_wdata_i      : LS request, byte strobes (0 = read), addr, data
//   ls_gnt_o, ls_rvalid_o      : LS accepted this cycle / LS response pulse
//   rdata_o, err_o             : response data and timeout flag, qualified by
//                                either rvalid pulse, held until the next one
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o    : memory-side request and captured fields
//   mem_gnt_i                  : memory accepted the request
//   mem_rvalid_i, mem_rdata_i  : memory response and read data
// -----------------------------------------------------------------------------
module mem_arb #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,

   input  logic        ls_req_i,
   input  logic [3:0]  ls_we_i,
   input  logic [31:0] ls_addr_i,
   input  logic [31:0] ls_wdata_i,
   output logic        ls_gnt_o,
   output logic        ls_rvalid_o,

   output logic [31:0] rdata_o,
   output logic        err_o,

   output logic        mem_req_o,
   output logic [3:0]  mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   typedef enum logic {
      OWN_IF,
      OWN_LS
   } owner_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t      state;
   state_t      state_nxt;

   // The port granted most recently is also the owner of the access in
   // flight, so one register serves as both round-robin pointer and owner.
   owner_t      owner;

   logic [3:0]  we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [7:0]  wait_cnt;

   logic        gnt_if;
   logic        gnt_ls;
   logic        resp_hit;
   logic        expired;

   // ---------------------------------------------------------------------------
   // Next state, arbitration and WAIT-exit decisions
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      gnt_if    = 1'b0;
      gnt_ls    = 1'b0;
      resp_hit  = 1'b0;
      expired   = 1'b0;

      case (state)
         S_IDLE: begin
            // Grants are suppressed while reset is held so all outputs read 0.
            if (!rst_i) begin
               if (if_req_i && ls_req_i) begin
                  // Tie: the port that did not win last time goes first.
                  if (owner == OWN_IF) begin
                     gnt_ls = 1'b1;
                  end else begin
                     gnt_if = 1'b1;
                  end
               end else begin
                  gnt_if = if_req_i;
                  gnt_ls = ls_req_i;
               end
            end
            if (gnt_if || gnt_ls) begin
               state_nxt = S_ISSUE;
            end
         end

         S_ISSUE: begin
            if (mem_gnt_i) begin
               state_nxt = S_WAIT;
            end
         end

         S_WAIT: begin
            // A response on the expiry cycle takes priority over the timeout.
            resp_hit = mem_rvalid_i;
            expired  = (wait_cnt == TIMEOUT_CNT);
            if (resp_hit || expired) begin
               state_nxt = S_RESP;
            end
         end

         S_RESP: begin
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register and datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= S_IDLE;
         owner    <= OWN_IF;
         we_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         wait_cnt <= '0;
      end else begin
         state <= state_nxt;

         if (gnt_ls) begin
            owner   <= OWN_LS;
            we_q    <= ls_we_i;
            addr_q  <= ls_addr_i;
            wdata_q <= ls_wdata_i;
         end else if (gnt_if) begin
            owner   <= OWN_IF;
            we_q    <= '0;
            addr_q  <= if_addr_i;
            wdata_q <= '0;
         end

         // Counter counts WAIT cycles starting from 0 on the first WAIT cycle.
         if (state == S_ISSUE && mem_gnt_i) begin
            wait_cnt <= '0;
         end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 8'd1;
         end

         if (resp_hit) begin
            rdata_q <= (we_q == '0) ? mem_rdata_i : '0;
            err_q   <= 1'b0;
         end else if (expired) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign if_gnt_o    = gnt_if;
   assign ls_gnt_o    = gnt_ls;

   // The response pulse is masked during reset so an aborted access never
   // reports completion.
   assign if_rvalid_o = (state == S_RESP) && (owner == OWN_IF) && !rst_i;
   assign ls_rvalid_o = (state == S_RESP) && (owner == OWN_LS) && !rst_i;

   assign rdata_o     = rdata_q;
   assign err_o       = err_q;

   assign mem_req_o   = (state == S_ISSUE);
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_arb
//   Self-checking bench for mem_arb. A transaction-level model tracks the
//   round-robin pointer and which requests are pending, and predicts, for each
//   access, the grant, the memory-side fields, the cycle in which the response
//   is returned and its data/err from the memory delays the bench chooses.
// -----------------------------------------------------------------------------
module tb_mem_arb;

   localparam int T = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_gnt_o;
   logic        if_rvalid_o;
   logic        ls_req_i;
   logic [3:0]  ls_we_i;
   logic [31:0] ls_addr_i;
   logic [31:0] ls_wdata_i;
   logic        ls_gnt_o;
   logic        ls_rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        mem_req_o;
   logic [3:0]  mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   int n_vec = 0;
   int n_err = 0;

   // model: 1 when the last grant went to LS
   bit last_ls;

   mem_arb #(.TIMEOUT(T)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_gnt_o    (if_gnt_o),
      .if_rvalid_o (if_rvalid_o),
      .ls_req_i    (ls_req_i),
      .ls_we_i     (ls_we_i),
      .ls_addr_i   (ls_addr_i),
      .ls_wdata_i  (ls_wdata_i),
      .ls_gnt_o    (ls_gnt_o),
      .ls_rvalid_o (ls_rvalid_o),
      .rdata_o     (rdata_o),
      .err_o       (err_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_gnt_i   (mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i (mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_if_gnt"},    32'(if_gnt_o),    32'd0);
      chk({tag, "_ls_gnt"},    32'(ls_gnt_o),    32'd0);
      chk({tag, "_if_rvalid"}, 32'(if_rvalid_o), 32'd0);
      chk({tag, "_ls_rvalid"}, 32'(ls_rvalid_o), 32'd0);
   endtask

   // One complete access starting in IDLE. a_if/a_ls raise a new request on
   // that port unless one is already pending (pending fields stay stable).
   // gw = cycles mem_gnt is withheld, rw = WAIT cycle (1-based) carrying
   // mem_rvalid; rw beyond T+1 means the memory never answers in time.
   task automatic access(input bit a_if, input bit a_ls,
                         input logic [31:0] ia, input logic [3:0] we,
                         input logic [31:0] la, input logic [31:0] wd,
                         input int gw, input int rw, input logic [31:0] md);
      bit          win_ls;
      bit          timeout;
      bit          done;
      int          k;
      logic [3:0]  e_we;
      logic [31:0] e_addr, e_wdata, e_rdata;

      if (a_if && !if_req_i) begin
         if_req_i  = 1'b1;
         if_addr_i = ia;
      end
      if (a_ls && !ls_req_i) begin
         ls_req_i   = 1'b1;
         ls_we_i    = we;
         ls_addr_i  = la;
         ls_wdata_i = wd;
      end
      win_ls  = (if_req_i && ls_req_i) ? !last_ls : ls_req_i;
      e_we    = win_ls ? ls_we_i    : 4'h0;
      e_addr  = win_ls ? ls_addr_i  : if_addr_i;
      e_wdata = win_ls ? ls_wdata_i : 32'h0;

      @(negedge clk_i);
      chk("if_gnt", 32'(if_gnt_o), 32'(!win_ls));
      chk("ls_gnt", 32'(ls_gnt_o), 32'(win_ls));
      last_ls = win_ls;
      step();
      if (win_ls) ls_req_i = 1'b0;
      else        if_req_i = 1'b0;

      // ISSUE
      for (int c = 0; c <= gw; c++) begin
         mem_gnt_i = (c == gw);
         @(negedge clk_i);
         chk("issue_req",   32'(mem_req_o), 32'd1);
         chk("issue_addr",  mem_addr_o,     e_addr);
         chk("issue_we",    32'(mem_we_o),  32'(e_we));
         chk("issue_wdata", mem_wdata_o,    e_wdata);
         chk_quiet("issue");
         step();
      end
      mem_gnt_i = 1'b0;

      // WAIT
      timeout = 1'b0;
      done    = 1'b0;
      k       = 0;
      while (!done) begin
         mem_rvalid_i = (k == rw - 1);
         mem_rdata_i  = mem_rvalid_i ? md : $urandom;
         @(negedge clk_i);
         chk("wait_req", 32'(mem_req_o), 32'd0);
         chk_quiet("wait");
         if (k == rw - 1) begin
            done = 1'b1;
         end else if (k == T) begin
            done    = 1'b1;
            timeout = 1'b1;
         end
         step();
         k++;
      end

      // RESP; after a timeout the late memory response shows up here
      mem_rvalid_i = timeout;
      mem_rdata_i  = $urandom;
      e_rdata = (timeout || e_we != 4'h0) ? 32'h0 : md;
      @(negedge clk_i);
      chk("resp_if_rvalid", 32'(if_rvalid_o), 32'(!win_ls));
      chk("resp_ls_rvalid", 32'(ls_rvalid_o), 32'(win_ls));
      chk("resp_rdata",     rdata_o,          e_rdata);
      chk("resp_err",       32'(err_o),       32'(timeout));
      chk("resp_if_gnt",    32'(if_gnt_o),    32'd0);
      chk("resp_ls_gnt",    32'(ls_gnt_o),    32'd0);
      chk("resp_req",       32'(mem_req_o),   32'd0);
      step();
      mem_rvalid_i = 1'b0;
   endtask

   initial begin
      rst_i        = 1'b1;
      if_req_i     = 1'b0;
      if_addr_i    = '0;
      ls_req_i     = 1'b0;
      ls_we_i      = '0;
      ls_addr_i    = '0;
      ls_wdata_i   = '0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      last_ls      = 1'b0;

      // Reset state
      step();
      step();
      @(negedge clk_i);
      chk_quiet("rst");
      chk("rst_req",   32'(mem_req_o), 32'd0);
      chk("rst_we",    32'(mem_we_o),  32'd0);
      chk("rst_addr",  mem_addr_o,     32'd0);
      chk("rst_wdata", mem_wdata_o,    32'd0);
      chk("rst_rdata", rdata_o,        32'd0);
      chk("rst_err",   32'(err_o),     32'd0);
      step();
      rst_i = 1'b0;

      // Simultaneous requests after reset: LS, IF, LS, IF
      access(1'b1, 1'b1, 32'h0000_0040, 4'h0, 32'h0000_0080, 32'h0, 0, 1, 32'h1111_1111);
      access(1'b0, 1'b1, 32'h0, 4'h0, 32'h0000_0084, 32'h0, 0, 1, 32'h2222_2222);
      access(1'b1, 1'b0, 32'h0000_0044, 4'h0, 32'h0, 32'h0, 1, 2, 32'h3333_3333);
      access(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h4444_4444);

      // IF-only read of 0x100 with minimum latency
      access(1'b1, 1'b0, 32'h0000_0100, 4'h0, 32'h0, 32'h0, 0, 1, 32'hDEAD_BEEF);

      // LS store with mem_gnt delayed three cycles
      access(1'b0, 1'b1, 32'h0, 4'b0011, 32'h0000_0204, 32'h1234_ABCD, 3, 1, 32'h5555_5555);

      // Memory never answers: timeout, then a stale response in IDLE
      access(1'b0, 1'b1, 32'h0, 4'h0, 32'h0000_0300, 32'h0, 0, 1000, 32'h6666_6666);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hBAD0_BAD0;
      @(negedge clk_i);
      chk_quiet("stale_idle");
      chk("stale_idle_req", 32'(mem_req_o), 32'd0);
      step();
      mem_rvalid_i = 1'b0;
      @(negedge clk_i);
      chk_quiet("stale_after");
      chk("stale_after_req", 32'(mem_req_o), 32'd0);
      chk("stale_after_err", 32'(err_o),     32'd1);
      step();

      // Response on the expiry cycle wins over the timeout
      access(1'b0, 1'b1, 32'h0, 4'h0, 32'h0000_0308, 32'h0, 0, T + 1, 32'h7777_7777);

      // Randomized accesses
      for (int i = 0; i < 40; i++) begin
         bit a_if, a_ls;
         a_if = 1'($urandom_range(1, 0));
         a_ls = 1'($urandom_range(1, 0));
         if (!a_if && !a_ls && !if_req_i && !ls_req_i) a_ls = 1'b1;
         access(a_if, a_ls, $urandom, ($urandom_range(1, 0) == 1) ? 4'($urandom) : 4'h0,
                $urandom, $urandom, $urandom_range(3, 0), $urandom_range(T + 3, 1), $urandom);
      end
      while (if_req_i || ls_req_i) begin
         access(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 0, 1, $urandom);
      end

      // Reset during WAIT aborts the access; pending IF granted right after
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0500;
      @(negedge clk_i);
      chk("pre_rst_if_gnt", 32'(if_gnt_o), 32'd1);
      step();
      if_req_i  = 1'b0;
      mem_gnt_i = 1'b1;
      @(negedge clk_i);
      chk("pre_rst_req", 32'(mem_req_o), 32'd1);
      step();
      mem_gnt_i = 1'b0;
      rst_i     = 1'b1;
      @(negedge clk_i);
      chk("rst_wait_req", 32'(mem_req_o), 32'd0);
      step();
      if_req_i     = 1'b1;
      if_addr_i    = 32'h0000_0600;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hFEED_F00D;
      @(negedge clk_i);
      chk_quiet("rst2");
      chk("rst2_req",   32'(mem_req_o), 32'd0);
      chk("rst2_we",    32'(mem_we_o),  32'd0);
      chk("rst2_addr",  mem_addr_o,     32'd0);
      chk("rst2_wdata", mem_wdata_o,    32'd0);
      chk("rst2_rdata", rdata_o,        32'd0);
      chk("rst2_err",   32'(err_o),     32'd0);
      step();
      rst_i        = 1'b0;
      mem_rvalid_i = 1'b0;
      last_ls      = 1'b0;
      access(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 0, 2, 32'h8888_8888);
      // Pointer back at IF after reset: the next tie goes to LS
      access(1'b1, 1'b1, 32'h0000_0700, 4'h0, 32'h0000_0704, 32'h0, 0, 1, 32'h9999_9999);
      access(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hAAAA_AAAA);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Bound on total run time
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/mem_arb.md
# mem_arb

Single-port memory arbiter and sequencer sharing one unified instruction/data memory between the instruction-fetch stage (IF) and the load/store unit (LS). It accepts one request at a time, arbitrates round-robin, drives the memory-side request/grant handshake, waits for the read/write response, and returns the response to the owning requester. A watchdog ends a stalled access with an error. It replaces the separate instruction and data memories of the single-cycle core once the core moves to a shared memory.

## Interface
- `TIMEOUT`, 255: maximum WAIT cycles before an access is aborted with error; range 1..255.
- `clk_i` input 1: clock; all state updates on rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `if_req_i` input 1: IF read request; held with `if_addr_i` stable until granted.
- `if_addr_i` input 32: IF word address.
- `if_gnt_o` output 1: IF request accepted this cycle.
- `if_rvalid_o` output 1: one-cycle pulse, IF response valid.
- `ls_req_i` input 1: LS request; held with fields stable until granted.
- `ls_we_i` input 4: LS byte write strobes; 4'b0000 = read, same encoding as the control unit's `mem_wr` field.
- `ls_addr_i` input 32: LS address.
- `ls_wdata_i` input 32: LS store data.
- `ls_gnt_o` output 1: LS request accepted this cycle.
- `ls_rvalid_o` output 1: one-cycle pulse, LS response valid (also for writes).
- `rdata_o` output 32: response data, valid with either rvalid pulse.
- `err_o` output 1: timeout flag, valid with either rvalid pulse.
- `mem_req_o` output 1: memory request.
- `mem_we_o` output 4: memory byte strobes.
- `mem_addr_o` output 32, `mem_wdata_o` output 32: memory address and write data.
- `mem_gnt_i` input 1: memory accepted request.
- `mem_rvalid_i` input 1: memory response; never in the same cycle as its `mem_gnt_i`.
- `mem_rdata_i` input 32: memory read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request is present, pick a winner, assert that port's `*_gnt_o` combinationally this cycle, and capture addr/we/wdata (IF: we=0, wdata=0) plus owner. Next state is ISSUE. If no request, stay in IDLE.
- Arbitration: one request only wins it. When both request, the port not granted last wins. The last-grant pointer resets to IF, so the first tie goes to LS. The pointer updates on every grant.
- ISSUE: `mem_req_o`=1 with captured fields. On `mem_gnt_i` go to WAIT and clear the watchdog counter; otherwise hold. No timeout in ISSUE.
- WAIT: `mem_req_o`=0 and an 8-bit counter increments each cycle. On `mem_rvalid_i`, register `mem_rdata_i` (0 for writes), set err=0, and go to RESP. If instead the counter reaches `TIMEOUT`, set rdata=0, err=1, and go to RESP. If `mem_rvalid_i` arrives on the expiry cycle, the response wins and err=0.
- RESP: pulse the owner's `*_rvalid_o` for exactly one cycle with `rdata_o`/`err_o`, then go to IDLE. No grant is given in RESP.
- `mem_rvalid_i` outside WAIT is ignored, including stale responses arriving after a reset.
- Requests arriving while busy wait un-granted until IDLE. A request dropped before grant is simply never granted.

## Timing
- Reset values: state=IDLE, pointer=IF. All outputs are 0: gnt, rvalid, err, mem_req, mem_we, mem_addr, mem_wdata, rdata.
- Reset in any state aborts the access: no rvalid, and `mem_req_o` drops the next cycle.
- Minimum access: req+gnt at c0, mem_req at c1 (mem_gnt at c1), mem_rvalid at c2, rvalid_o at c3, next grant possible at c4. Back-to-back throughput is one access per 4 cycles.
- Response latency is 3 + (mem_gnt wait cycles) + (mem_rvalid wait cycles beyond 1).
- Timeout: rvalid_o with err=1 appears `TIMEOUT`+1 cycles after entering WAIT.
- `rdata_o`/`err_o` are registered and hold until the next RESP. Only the rvalid pulse marks them valid.

## Test plan
- IF-only read of 0x100: memory grants at once and returns 0xDEADBEEF one cycle later -> `if_gnt_o` at c0, `mem_addr_o`=0x100/`mem_we_o`=0 at c1, `if_rvalid_o`=1 with `rdata_o`=0xDEADBEEF at c3, `err_o`=0.
- Simultaneous IF and LS requests after reset, both held -> LS granted first, then IF at the next IDLE, then LS again (alternation). No port is granted twice in a row while the other waits.
- LS store `ls_we_i`=4'b0011, addr 0x204, wdata 0x1234ABCD, mem_gnt delayed 3 cycles -> `mem_req_o` high 4 cycles with stable fields, `ls_rvalid_o` pulse with `rdata_o`=0.
- Memory never responds, TIMEOUT=4 -> `ls_rvalid_o` with `err_o`=1 five cycles after WAIT entry. A later `mem_rvalid_i` in IDLE causes no output.
- `mem_rvalid_i` on the timeout-expiry cycle -> response returned, `err_o`=0.
- `rst_i` asserted in WAIT -> next cycle all outputs 0, state IDLE, no rvalid. A pending IF request is granted the cycle after reset deasserts.
